sd_dat_rx_crc16: RTL and testbench
==================================

Name: sd_dat_rx_crc16

Overview:
- Receive side of the SD card 1-bit DAT0 data-block path. The existing CRC16 generator serves the transmit path.
- Once armed, the block:
  - waits for the start bit;
  - deserialises BLOCK_BYTES data bytes MSB-first and streams them out;
  - computes CRC16 over the data on the fly;
  - captures the 16 card-sent CRC bits and checks the end bit;
  - reports done, CRC error, end-bit error or start timeout.
- Sits between the SD pin sampler and the sector buffer writer in SDCard_Interface.

Parameters:
- BLOCK_BYTES, 512, data bytes per block (1..4096).
- START_TIMEOUT, 65535, number of BIT_STRB pulses allowed in WAIT_START before TIMEOUT.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-CLK pulse; arms reception of one block (accepted only in IDLE).
- BIT_STRB  in  1  one-CLK pulse per SD clock rising edge; DAT0 is valid when high.
- DAT0  in  1  sampled SD DAT0 line.
- BYTE_OUT  out  8  received data byte.
- BYTE_VALID  out  1  one-CLK pulse; BYTE_OUT valid.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-CLK pulse at end of block (good, bad or timeout).
- CRC_ERR  out  1  computed CRC differs from received CRC; held until next accepted START.
- END_ERR  out  1  end bit sampled 0; held until next accepted START.
- TIMEOUT  out  1  no start bit within START_TIMEOUT strobes; held until next accepted START.
- CRC_CALC  out  16  running or final computed CRC16.
- CRC_RX  out  16  CRC16 received from the card.

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0, CRC register 0.
- Reset wins over every other input in the same cycle. RESET mid-block abandons the block with no DONE pulse.
- General rules:
  - All bit processing is gated by BIT_STRB. Cycles without a strobe hold all state.
  - BIT_STRB in IDLE is ignored.
  - START is ignored while BUSY. START and BIT_STRB in the same IDLE cycle: arm only; that strobe is not consumed.
- CRC16 definition:
  - Polynomial x^16+x^12+x^5+1, init 0x0000, MSB-first, no final XOR.
  - Update per data bit: fb = DAT0 ^ crc[15]; crc = {crc[14:0],fb} ^ (fb ? 0x1020 : 0).
  - Start, CRC and end bits are never fed into the LFSR.
- States:
  - IDLE: on START, clear CRC_ERR/END_ERR/TIMEOUT, CRC register, byte and bit counters and timeout counter, then go to WAIT_START.
  - WAIT_START: on each strobe:
    - DAT0=0 -> DATA; this is the start bit, not shifted.
    - DAT0=1 -> timeout count +1. When the count reaches START_TIMEOUT, assert TIMEOUT, pulse DONE on the next cycle, go to IDLE.
  - DATA: on each strobe, shift DAT0 into the byte shift register and update the CRC.
    - On the 8th bit, BYTE_OUT/BYTE_VALID appear on the cycle after the strobe (1-CLK latency).
    - After byte BLOCK_BYTES-1 completes, go to CRC.
  - CRC: 16 strobes shift DAT0 into CRC_RX MSB-first, then go to END_BIT.
  - END_BIT: on the strobe:
    - END_ERR = ~DAT0.
    - CRC_ERR = (CRC_RX != CRC_CALC).
    - DONE pulses on the following cycle together with the final flag values; go to IDLE.
- Counter widths: byte counter is clog2(BLOCK_BYTES+1) bits, bit counter 3 bits, CRC bit counter 4 bits. Wrap-around is never relied on.
- Back-to-back strobes on consecutive CLK cycles are supported at full rate, including the strobe immediately after a byte boundary.
- CRC_CALC is frozen after the last data bit until the next accepted START.

Test Plan:
- 512 bytes 0xFF, CRC 0x7FA1 sent, end bit 1 -> 512 BYTE_VALID pulses of 0xFF, CRC_CALC=0x7FA1, CRC_RX=0x7FA1, DONE pulse, all error flags 0.
- Same block with CRC bit 0 flipped (0x7FA0 sent) -> DONE, CRC_ERR=1, END_ERR=0, CRC_CALC=0x7FA1.
- Good block with end bit 0 -> DONE, END_ERR=1, CRC_ERR=0.
- START_TIMEOUT=16, DAT0 held 1 for 20 strobes -> TIMEOUT=1 and DONE after the 16th strobe, zero BYTE_VALID; a following START clears TIMEOUT.
- BLOCK_BYTES=4, bytes 0x12,0x34,0x56,0x78 at one strobe every CLK, RESET pulsed after byte 2 -> exactly 2 BYTE_VALID, no DONE, all outputs 0, IDLE. A new START plus the full block -> CRC_CALC equals the reference-model value, no errors.
- START asserted while BUSY and BIT_STRB in IDLE -> no state change; the block in progress completes normally.

Source files
------------

// File: rtl/sd_dat_rx_crc16.sv
// SD card DAT0 (1-bit bus) data-block receiver with on-the-fly CRC16 check.
// Waits for the start bit and deserialises BLOCK_BYTES bytes MSB-first.
// Then it captures the card's CRC16, checks the end bit and reports status.
module sd_dat_rx_crc16 #(
    parameter int unsigned BLOCK_BYTES   = 512,
    parameter int unsigned START_TIMEOUT = 65535
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        BIT_STRB,
    input  logic        DAT0,
    output logic [7:0]  BYTE_OUT,
    output logic        BYTE_VALID,
    output logic        BUSY,
    output logic        DONE,
    output logic        CRC_ERR,
    output logic        END_ERR,
    output logic        TIMEOUT,
    output logic [15:0] CRC_CALC,
    output logic [15:0] CRC_RX
);

    localparam int unsigned BW = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] LAST_TO   = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_END_BIT
    } state_t;

    state_t        state;
    logic [BW-1:0] byte_cnt;
    logic [2:0]    bit_cnt;
    logic [3:0]    crc_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shift;

    logic          fb;
    logic [15:0]   crc_next;
    logic [7:0]    shift_next;

    // Next CRC and shift-register values for the bit currently on DAT0
    always_comb begin
        fb         = DAT0 ^ CRC_CALC[15];
        crc_next   = {CRC_CALC[14:0], fb} ^ (fb ? 16'h1020 : 16'h0000);
        shift_next = {shift[6:0], DAT0};
    end

    // Receive FSM; every output is a register updated here
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            crc_cnt    <= '0;
            to_cnt     <= '0;
            shift      <= '0;
            BYTE_OUT   <= '0;
            BYTE_VALID <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            CRC_ERR    <= 1'b0;
            END_ERR    <= 1'b0;
            TIMEOUT    <= 1'b0;
            CRC_CALC   <= '0;
            CRC_RX     <= '0;
        end else begin
            BYTE_VALID <= 1'b0;
            DONE       <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A strobe arriving together with START is not consumed
                    if (START) begin
                        CRC_ERR  <= 1'b0;
                        END_ERR  <= 1'b0;
                        TIMEOUT  <= 1'b0;
                        CRC_CALC <= '0;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        crc_cnt  <= '0;
                        to_cnt   <= '0;
                        BUSY     <= 1'b1;
                        state    <= S_WAIT_START;
                    end
                end

                S_WAIT_START: begin
                    if (BIT_STRB) begin
                        if (!DAT0) begin
                            // Start bit: framing only, not part of the data or CRC
                            state <= S_DATA;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                            if (to_cnt == LAST_TO) begin
                                TIMEOUT <= 1'b1;
                                DONE    <= 1'b1;
                                BUSY    <= 1'b0;
                                state   <= S_IDLE;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (BIT_STRB) begin
                        shift    <= shift_next;
                        CRC_CALC <= crc_next;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt    <= '0;
                            BYTE_OUT   <= shift_next;
                            BYTE_VALID <= 1'b1;
                            byte_cnt   <= byte_cnt + 1'b1;
                            if (byte_cnt == LAST_BYTE) begin
                                state <= S_CRC;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                S_CRC: begin
                    // CRC_CALC is left untouched from here on
                    if (BIT_STRB) begin
                        CRC_RX <= {CRC_RX[14:0], DAT0};
                        if (crc_cnt == 4'd15) begin
                            crc_cnt <= '0;
                            state   <= S_END_BIT;
                        end else begin
                            crc_cnt <= crc_cnt + 1'b1;
                        end
                    end
                end

                S_END_BIT: begin
                    if (BIT_STRB) begin
                        END_ERR <= ~DAT0;
                        CRC_ERR <= (CRC_RX != CRC_CALC);
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_rx_crc16.sv
// Bench for sd_dat_rx_crc16: a 4-byte and a 512-byte instance share one stimulus bus.
// Received bytes are checked against a scoreboard queue.
module tb_sd_dat_rx_crc16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic strb = 1'b0;
    logic dat = 1'b1;
    logic sel = 1'b0; // 0: 4-byte instance, 1: 512-byte instance

    logic [7:0]  bo_a, bo_b;
    logic        bv_a, bv_b, busy_a, busy_b, done_a, done_b;
    logic        ce_a, ce_b, ee_a, ee_b, to_a, to_b;
    logic [15:0] cc_a, cc_b, cr_a, cr_b;

    logic [7:0]  m_bo;
    logic        m_bv, m_busy, m_done, m_ce, m_ee, m_to;
    logic [15:0] m_cc, m_cr;

    int checks = 0;
    int errors = 0;
    int bv_cnt = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_bytes[$];
    logic [7:0] mon_exp;

    typedef struct {
        logic [31:0] data;
        logic [15:0] crc_xor;
        logic        endb;
        logic        exp_ce;
        logic        exp_ee;
        int          gap;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    sd_dat_rx_crc16 #(.BLOCK_BYTES(4), .START_TIMEOUT(16)) u_small (
        .CLK(clk), .RESET(rst), .START(start & ~sel), .BIT_STRB(strb & ~sel), .DAT0(dat),
        .BYTE_OUT(bo_a), .BYTE_VALID(bv_a), .BUSY(busy_a), .DONE(done_a),
        .CRC_ERR(ce_a), .END_ERR(ee_a), .TIMEOUT(to_a), .CRC_CALC(cc_a), .CRC_RX(cr_a)
    );

    sd_dat_rx_crc16 #(.BLOCK_BYTES(512), .START_TIMEOUT(16)) u_big (
        .CLK(clk), .RESET(rst), .START(start & sel), .BIT_STRB(strb & sel), .DAT0(dat),
        .BYTE_OUT(bo_b), .BYTE_VALID(bv_b), .BUSY(busy_b), .DONE(done_b),
        .CRC_ERR(ce_b), .END_ERR(ee_b), .TIMEOUT(to_b), .CRC_CALC(cc_b), .CRC_RX(cr_b)
    );

    assign m_bo   = sel ? bo_b   : bo_a;
    assign m_bv   = sel ? bv_b   : bv_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_ce   = sel ? ce_b   : ce_a;
    assign m_ee   = sel ? ee_b   : ee_a;
    assign m_to   = sel ? to_b   : to_a;
    assign m_cc   = sel ? cc_b   : cc_a;
    assign m_cr   = sel ? cr_b   : cr_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pop on every byte, count DONE pulses
    always @(negedge clk) begin
        if (m_bv) begin
            bv_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %h, expected none", m_bo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("byte_out", {24'h0, m_bo}, {24'h0, mon_exp});
            end
        end
        if (m_done) done_cnt++;
    end

    // Reference CRC16 (x^16+x^12+x^5+1, init 0) over the first n bytes of tx_bytes
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c = 16'h0000;
        logic        f;
        for (int i = 0; i < n; i++) begin
            for (int j = 7; j >= 0; j--) begin
                f = tx_bytes[i][j] ^ c[15];
                c = {c[14:0], 1'b0};
                if (f) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic strobe(input logic b, input int gap);
        strb = 1'b1;
        dat  = b;
        @(posedge clk);
        #1;
        strb = 1'b0;
        dat  = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // inject: arm with a simultaneous strobe, and pulse START during data bits
    task automatic run_block(input int nbytes, input logic [15:0] crc_tx, input logic endb,
                             input int gap, input bit inject);
        logic [7:0] b;
        start = 1'b1;
        if (inject) begin
            strb = 1'b1;
            dat  = 1'b0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        strb  = 1'b0;
        dat   = 1'b1;
        strobe(1'b1, gap);
        strobe(1'b1, gap);
        strobe(1'b0, gap);
        for (int i = 0; i < nbytes; i++) begin
            b = tx_bytes[i];
            exp_q.push_back(b);
            for (int j = 7; j >= 0; j--) begin
                if (inject && j == 3) start = 1'b1;
                strobe(b[j], gap);
                start = 1'b0;
            end
        end
        for (int k = 15; k >= 0; k--) strobe(crc_tx[k], gap);
        strobe(endb, gap);
    endtask

    task automatic check_block(input int nbytes, input logic [15:0] exp_calc,
                               input logic [15:0] exp_rx, input logic ce, input logic ee,
                               input int b0, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'h0, done_cnt != d0}, 32'h1);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("byte_valid_count", bv_cnt - b0, nbytes);
        check("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
        check("crc_calc", {16'h0, m_cc}, {16'h0, exp_calc});
        check("crc_rx", {16'h0, m_cr}, {16'h0, exp_rx});
        check("crc_err", {31'h0, m_ce}, {31'h0, ce});
        check("end_err", {31'h0, m_ee}, {31'h0, ee});
        check("timeout_clear", {31'h0, m_to}, 32'h0);
        check("busy_after_done", {31'h0, m_busy}, 32'h0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {m_bo, m_bv, m_busy, m_done, m_ce, m_ee, m_to}, 32'h0);
        check({name, "_crc"}, {m_cc, m_cr}, 32'h0);
    endtask

    initial begin
        int b0, d0;
        logic [15:0] ref_crc;

        vecs[0] = '{32'h12345678, 16'h0000, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{32'h00000000, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2] = '{32'hFFFFFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 0};
        vecs[3] = '{32'hA5C30F81, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
        vecs[4] = '{32'hDEADBEEF, 16'h8000, 1'b0, 1'b1, 1'b1, 1};

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        check_all_zero("reset_small");
        sel = 1'b1;
        #1;
        check_all_zero("reset_big");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 512 x 0xFF: good, bad CRC, bad end bit
        tx_bytes.delete();
        for (int i = 0; i < 512; i++) tx_bytes.push_back(8'hFF);
        b0 = bv_cnt; d0 = done_cnt;
        run_block(512, 16'h7FA1, 1'b1, 0, 1'b0);
        check_block(512, 16'h7FA1, 16'h7FA1, 1'b0, 1'b0, b0, d0);
        b0 = bv_cnt; d0 = done_cnt;
        run_block(512, 16'h7FA0, 1'b1, 0, 1'b0);
        check_block(512, 16'h7FA1, 16'h7FA0, 1'b1, 1'b0, b0, d0);
        b0 = bv_cnt; d0 = done_cnt;
        run_block(512, 16'h7FA1, 1'b0, 0, 1'b0);
        check_block(512, 16'h7FA1, 16'h7FA1, 1'b0, 1'b1, b0, d0);

        // Start-bit timeout after 16 strobes of DAT0=1
        b0 = bv_cnt; d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 15; i++) strobe(1'b1, 1);
        check("timeout_early", {30'h0, m_to, m_busy}, 32'h1);
        check("done_early", done_cnt - d0, 0);
        strobe(1'b1, 0);
        check("timeout_flag", {29'h0, m_to, m_done, m_busy}, 32'h6);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1);
        @(negedge clk);
        check("timeout_done_pulses", done_cnt - d0, 1);
        check("timeout_no_bytes", bv_cnt - b0, 0);
        check("timeout_held", {31'h0, m_to}, 32'h1);
        pulse_start();
        check("timeout_cleared", {30'h0, m_to, m_busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven 4-byte blocks
        sel = 1'b0;
        #1;
        for (int v = 0; v < 5; v++) begin
            tx_bytes.delete();
            for (int k = 3; k >= 0; k--) tx_bytes.push_back(vecs[v].data[k*8 +: 8]);
            ref_crc = crc_model(4);
            b0 = bv_cnt; d0 = done_cnt;
            run_block(4, ref_crc ^ vecs[v].crc_xor, vecs[v].endb, vecs[v].gap, 1'b0);
            check_block(4, ref_crc, ref_crc ^ vecs[v].crc_xor, vecs[v].exp_ce,
                        vecs[v].exp_ee, b0, d0);
        end

        // Reset in the middle of a full-rate block
        tx_bytes.delete();
        tx_bytes.push_back(8'h12); tx_bytes.push_back(8'h34);
        tx_bytes.push_back(8'h56); tx_bytes.push_back(8'h78);
        b0 = bv_cnt; d0 = done_cnt;
        pulse_start();
        strobe(1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(tx_bytes[i]);
            for (int j = 7; j >= 0; j--) strobe(tx_bytes[i][j], 0);
        end
        for (int j = 7; j >= 5; j--) strobe(tx_bytes[2][j], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_bytes", bv_cnt - b0, 2);
        check("mid_reset_no_done", done_cnt - d0, 0);
        check("mid_reset_queue", exp_q.size(), 0);
        exp_q.delete();
        check_all_zero("mid_reset_idle");
        @(posedge clk);
        #1;
        ref_crc = crc_model(4);
        b0 = bv_cnt; d0 = done_cnt;
        run_block(4, ref_crc, 1'b1, 0, 1'b0);
        check_block(4, ref_crc, ref_crc, 1'b0, 1'b0, b0, d0);

        // Strobes in IDLE ignored; START+strobe arms only; START while busy ignored
        b0 = bv_cnt; d0 = done_cnt;
        for (int i = 0; i < 3; i++) strobe(1'b0, 1);
        @(negedge clk);
        check("idle_strobe_busy", {31'h0, m_busy}, 32'h0);
        check("idle_strobe_bytes", bv_cnt - b0, 0);
        tx_bytes.delete();
        tx_bytes.push_back(8'hC3); tx_bytes.push_back(8'h3C);
        tx_bytes.push_back(8'h01); tx_bytes.push_back(8'h80);
        ref_crc = crc_model(4);
        @(posedge clk);
        #1;
        run_block(4, ref_crc, 1'b1, 1, 1'b1);
        check_block(4, ref_crc, ref_crc, 1'b0, 1'b0, b0, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
